// File: rtl/exec_seq_8bits.sv
// Execute/write-back sequencer for the 8-register, 8-bit datapath.
// Each instruction takes four cycles: IDLE accept, READ, EXEC, then WB (or HALT).
module exec_seq_8bits (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [7:0]  rd1,
  input  logic [7:0]  rd2,
  output logic [2:0]  ra1,
  output logic [2:0]  ra2,
  output logic [2:0]  wa3,
  output logic [7:0]  wd3,
  output logic        we3,
  output logic        zf,
  output logic        cf,
  output logic        halted
);

  typedef enum logic [2:0] {StIdle, StRead, StExec, StWb, StHalt} state_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q;
  logic [7:0]  result_q, result_d;
  logic        zf_q, zf_d;
  logic        cf_q, cf_d;
  logic [3:0]  op;
  logic [8:0]  sum, diff;

  assign op = instr_q[15:12];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      instr_q  <= 16'h0000;
      result_q <= 8'h00;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (instr_valid && instr_ready) instr_q <= instr;
      if (state_q == StExec) begin
        result_q <= result_d;
        zf_q     <= zf_d;
        cf_q     <= cf_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (instr_valid && instr_ready) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = (op == 4'hF) ? StHalt : StWb;
      StWb:    state_d = StIdle;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // NOP, HALT and the unused codes keep both the result and the flags.
  always_comb begin
    sum      = {1'b0, rd1} + {1'b0, rd2};
    diff     = {1'b0, rd1} - {1'b0, rd2};
    result_d = result_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    case (op)
      4'h1: begin result_d = sum[7:0];          cf_d = sum[8];  end
      4'h2: begin result_d = diff[7:0];         cf_d = diff[8]; end
      4'h3: begin result_d = rd1 & rd2;         cf_d = 1'b0;    end
      4'h4: begin result_d = rd1 | rd2;         cf_d = 1'b0;    end
      4'h5: begin result_d = rd1 ^ rd2;         cf_d = 1'b0;    end
      4'h6: begin result_d = {rd1[6:0], 1'b0};  cf_d = rd1[7];  end
      4'h7: begin result_d = {1'b0, rd1[7:1]};  cf_d = rd1[0];  end
      4'h8: result_d = rd1;
      4'h9: result_d = instr_q[7:0];
      default: ;
    endcase
    if (op >= 4'h1 && op <= 4'h7) zf_d = (result_d == 8'h00);
  end

  assign instr_ready = (state_q == StIdle) && !rst;
  assign ra1         = instr_q[8:6];
  assign ra2         = instr_q[5:3];
  assign wa3         = instr_q[11:9];
  assign wd3         = result_q;
  assign zf          = zf_q;
  assign cf          = cf_q;
  assign halted      = (state_q == StHalt);
  // Register 0 is hard-wired: it is never written, but its flags still update.
  assign we3 = (state_q == StWb) && (op != 4'h0) && (op <= 4'h9) && (instr_q[11:9] != 3'd0);

endmodule

// File: tb/tb_exec_seq_8bits.sv
// Directed bench for exec_seq_8bits with a small register-file model on the
// read/write ports.
module tb_exec_seq_8bits;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  rd1, rd2, wd3;
  logic [2:0]  ra1, ra2, wa3;
  logic        we3, zf, cf, halted;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rf [8];

  exec_seq_8bits dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rd1(rd1), .rd2(rd2), .ra1(ra1), .ra2(ra2),
    .wa3(wa3), .wd3(wd3), .we3(we3), .zf(zf), .cf(cf), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (we3) rf[wa3] <= wd3;
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one instruction and returns 1 ns after the edge that enters WB.
  task automatic issue(input logic [15:0] i);
    int t;
    t = 0;
    instr = i;
    instr_valid = 1'b1;
    while (!instr_ready && t < 40) begin
      tick();
      t++;
    end
    check("accept_ready", 16'(instr_ready), 16'd1);
    tick();
    instr_valid = 1'b0;
    check("read_busy", 16'(instr_ready), 16'd0);
    check("read_we3", 16'(we3), 16'd0);
    tick();
    check("exec_busy", 16'(instr_ready), 16'd0);
    check("exec_we3", 16'(we3), 16'd0);
    tick();
  endtask

  task automatic wb(input string tag, input logic we, input logic [2:0] wa,
                    input logic [7:0] wd, input logic z, input logic c);
    check({tag, "_we3"}, 16'(we3), 16'(we));
    if (we) begin
      check({tag, "_wa3"}, 16'(wa3), 16'(wa));
      check({tag, "_wd3"}, 16'(wd3), 16'(wd));
    end
    check({tag, "_zf"}, 16'(zf), 16'(z));
    check({tag, "_cf"}, 16'(cf), 16'(c));
    check({tag, "_wb_busy"}, 16'(instr_ready), 16'd0);
    tick();
    check({tag, "_idle_ready"}, 16'(instr_ready), 16'd1);
    check({tag, "_idle_we3"}, 16'(we3), 16'd0);
  endtask

  initial begin : main
    logic [15:0] stream [3];
    int acc_cyc [3];
    int idx, rdy_cnt, n_wr;
    logic [2:0] wr_a [4];
    logic [7:0] wr_d [4];

    // Reset values
    tick();
    tick();
    check("rst_ready", 16'(instr_ready), 16'd0);
    check("rst_ra1", 16'(ra1), 16'd0);
    check("rst_ra2", 16'(ra2), 16'd0);
    check("rst_wa3", 16'(wa3), 16'd0);
    check("rst_wd3", 16'(wd3), 16'd0);
    check("rst_we3", 16'(we3), 16'd0);
    check("rst_flags", 16'({zf, cf}), 16'd0);
    check("rst_halted", 16'(halted), 16'd0);
    rst = 1'b0;
    #1;
    check("rel_ready", 16'(instr_ready), 16'd1);

    issue(16'h927F); wb("ldi_r1", 1, 3'd1, 8'h7F, 0, 0);
    issue(16'h9401); wb("ldi_r2", 1, 3'd2, 8'h01, 0, 0);
    issue(16'h1650);
    check("add_ra1", 16'(ra1), 16'd1);
    check("add_ra2", 16'(ra2), 16'd2);
    wb("add_80", 1, 3'd3, 8'h80, 0, 0);
    issue(16'h92FF); wb("ldi_ff", 1, 3'd1, 8'hFF, 0, 0);
    issue(16'h1650); wb("add_wrap", 1, 3'd3, 8'h00, 1, 1);
    issue(16'h2888); wb("sub_borrow", 1, 3'd4, 8'h02, 0, 1);
    issue(16'h7A80); wb("shr", 1, 3'd5, 8'h00, 1, 1);
    issue(16'h3C50); wb("and", 1, 3'd6, 8'h01, 0, 0);
    issue(16'h1050); wb("add_r0", 0, 3'd0, 8'h00, 1, 1);
    issue(16'hB000); wb("op_b", 0, 3'd0, 8'h00, 1, 1);
    issue(16'h8E40); wb("mov", 1, 3'd7, 8'hFF, 1, 1);
    issue(16'h6E40); wb("shl", 1, 3'd7, 8'hFE, 0, 1);

    // Streamed instructions with instr_valid held high
    stream[0] = 16'h9211;
    stream[1] = 16'h9422;
    stream[2] = 16'h9633;
    idx = 0;
    rdy_cnt = 0;
    n_wr = 0;
    instr = stream[0];
    instr_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (we3 && n_wr < 4) begin
        wr_a[n_wr] = wa3;
        wr_d[n_wr] = wd3;
        n_wr++;
      end
      if (instr_valid && instr_ready) begin
        acc_cyc[idx] = c;
        rdy_cnt++;
        tick();
        idx++;
        if (idx < 3) instr = stream[idx];
        else instr_valid = 1'b0;
      end else begin
        tick();
      end
    end
    instr_valid = 1'b0;
    check("stream_accepts", 16'(rdy_cnt), 16'd3);
    check("stream_writes", 16'(n_wr), 16'd3);
    if (rdy_cnt == 3) begin
      check("stream_acc1", 16'(acc_cyc[1] - acc_cyc[0]), 16'd4);
      check("stream_acc2", 16'(acc_cyc[2] - acc_cyc[1]), 16'd4);
    end
    if (n_wr >= 3) begin
      check("stream_w0", {5'd0, wr_a[0], wr_d[0]}, 16'h0111);
      check("stream_w1", {5'd0, wr_a[1], wr_d[1]}, 16'h0222);
      check("stream_w2", {5'd0, wr_a[2], wr_d[2]}, 16'h0333);
    end

    // HALT is sticky and blocks further accepts
    issue(16'hF000);
    check("halt_halted", 16'(halted), 16'd1);
    check("halt_we3", 16'(we3), 16'd0);
    instr = 16'h9201;
    instr_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check("halt_ready", 16'(instr_ready), 16'd0);
      tick();
    end
    check("halt_sticky", 16'(halted), 16'd1);
    instr_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("halt_rst_halted", 16'(halted), 16'd0);
    check("halt_rst_ready", 16'(instr_ready), 16'd1);

    // r1=0x11, r2=0x22: SUB r5,r1,r2 sets a nonzero result and borrow
    issue(16'h2A50); wb("sub_neg", 1, 3'd5, 8'hEF, 0, 1);

    // Reset while ADD r3,r1,r2 sits in EXEC
    instr = 16'h1650;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("abort_we3", 16'(we3), 16'd0);
    check("abort_wd3", 16'(wd3), 16'd0);
    check("abort_flags", 16'({zf, cf}), 16'd0);
    check("abort_ra", {7'd0, ra1, ra2, wa3}, 16'd0);
    check("abort_ready", 16'(instr_ready), 16'd0);
    tick();
    check("abort_we3_late", 16'(we3), 16'd0);
    rst = 1'b0;
    issue(16'h9C44); wb("resume_ldi", 1, 3'd6, 8'h44, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
